mdu: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage pipeline; owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency.
- Serves mfhi/mflo/mthi/mtlo.
- Drives Start/Busy to the hazard control unit, which stalls D-stage HI/LO-class instructions while either is high.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu_calc.sv | 70 +++++++
 rtl/mdu.sv | 93 +++++++++
 tb/tb_mdu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the MDUOp encodings, default latency constants and op-class helpers.
// The madd/maddu ops only count as mult-class when MDU_MADD_EN is defined.

package mdu_pkg;

  // E-stage operation encodings; codes 11-15 are treated as no-ops
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_op_e;

  // Default busy latencies for mult-class and div-class operations
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for every op that launches a multi-cycle operation
  function automatic logic is_md(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    r = 1'b1;
`endif
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the ops that use the divide latency
  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit {HI,LO} result generation for one op.
// Signed divide works on magnitudes and restores signs afterwards, so the
// 0x80000000 / -1 case yields LO=0x80000000, HI=0 without special casing.
// For a zero divisor the current {HI,LO} is passed through and div_by_zero
// is raised so the caller can suppress the commit.
// Optional feature: MDU_MADD_EN adds madd/maddu accumulate into {HI,LO}.

module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Low 64 bits of the product of sign-extended operands equal the signed product
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div_by_zero = (b == 32'd0);

  // Divisor forced to 1 on divide by zero so the dividers never see zero
  assign b_safe = div_by_zero ? 32'd1 : b;
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  assign a_mag      = a[31] ? (~a + 32'd1) : a;
  assign b_mag      = b[31] ? (~b + 32'd1) : b;
  assign b_mag_safe = div_by_zero ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;

  // Quotient is negative when operand signs differ; remainder follows the dividend
  assign q_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s = a[31] ? (~r_mag + 32'd1) : r_mag;

  // Select the 64-bit result for the requested op; non-arithmetic ops pass {HI,LO}
  always_comb begin
    result = {hi, lo};
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   if (!div_by_zero) result = {r_s, q_s};
      MDU_DIVU:  if (!div_by_zero) result = {r_u, q_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  result = {hi, lo} + prod_s;
      MDU_MADDU: result = {hi, lo} + prod_u;
`endif
      default:   result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the E stage; owns the architectural HI/LO.
// A mult/div-class op is accepted when idle (Start), its result is staged at
// once and committed to HI/LO after a fixed busy period. Ops arriving while
// busy are ignored. mfhi/mflo read the committed registers combinationally.
// Optional feature: define MDU_MADD_EN to enable madd (op 9) / maddu (op 10).

module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDU_Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      staged_hi;
  logic [31:0]      staged_lo;
  logic             staged_wr;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [63:0]      calc_result;
  logic             div_by_zero;

  mdu_calc u_calc (
    .op          (MDUOp),
    .a           (A),
    .b           (B),
    .hi          (hi_q),
    .lo          (lo_q),
    .result      (calc_result),
    .div_by_zero (div_by_zero)
  );

  assign Start = is_md(MDUOp) && !busy_q;
  assign Busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

  // Move-from reads always see the committed registers, even while busy
  always_comb begin
    MDU_Out = 32'd0;
    if (MDUOp == MDU_MFHI)      MDU_Out = hi_q;
    else if (MDUOp == MDU_MFLO) MDU_Out = lo_q;
  end

  // Launch, count down and commit; busy_q mirrors cnt != 0 and gates all writes
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      staged_hi <= 32'd0;
      staged_lo <= 32'd0;
      staged_wr <= 1'b0;
      cnt       <= '0;
      busy_q    <= 1'b0;
    end else if (Start) begin
      {staged_hi, staged_lo} <= calc_result;
      staged_wr              <= !div_by_zero;
      cnt                    <= is_div(MDUOp) ? DIV_CNT : MULT_CNT;
      busy_q                 <= 1'b1;
    end else if (busy_q) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        busy_q <= 1'b0;
        if (staged_wr) begin
          hi_q <= staged_hi;
          lo_q <= staged_lo;
        end
      end
    end else begin
      if (MDUOp == MDU_MTHI) hi_q <= A;
      if (MDUOp == MDU_MTLO) lo_q <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. A table of directed vectors (preload
// HI/LO, issue one op, count busy cycles, check committed HI/LO and mfhi/mflo)
// plus hand-written sequences for mthi, ops while busy and reset mid-operation.

module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] MDU_Out;
  logic [31:0] HI;
  logic [31:0] LO;

  int comparisons = 0;
  int failures    = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .MDUOp   (MDUOp),
    .A       (A),
    .B       (B),
    .Start   (Start),
    .Busy    (Busy),
    .MDU_Out (MDU_Out),
    .HI      (HI),
    .LO      (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    comparisons++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Loads HI then LO through mthi/mtlo; caller must be idle
  task automatic move_hilo(input logic [31:0] hi_v, input logic [31:0] lo_v);
    MDUOp = MDU_MTHI; A = hi_v; B = 32'd0;
    step();
    MDUOp = MDU_MTLO; A = lo_v;
    step();
    MDUOp = MDU_NONE; A = 32'd0;
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    int n;
    move_hilo(v.pre_hi, v.pre_lo);
    MDUOp = v.op; A = v.a; B = v.b;
    #1;
    check_output($sformatf("v%0d_start", idx), {31'd0, Start}, (v.cycles != 0) ? 32'd1 : 32'd0);
    check_output($sformatf("v%0d_idle", idx), {31'd0, Busy}, 32'd0);
    step();
    MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      check_output($sformatf("v%0d_hold_hi", idx), HI, v.pre_hi);
      check_output($sformatf("v%0d_hold_lo", idx), LO, v.pre_lo);
      n++;
      step();
    end
    check_output($sformatf("v%0d_busy_cycles", idx), 32'(n), 32'(v.cycles));
    check_output($sformatf("v%0d_hi", idx), HI, v.exp_hi);
    check_output($sformatf("v%0d_lo", idx), LO, v.exp_lo);
    MDUOp = MDU_MFHI;
    #1;
    check_output($sformatf("v%0d_mfhi", idx), MDU_Out, v.exp_hi);
    MDUOp = MDU_MFLO;
    #1;
    check_output($sformatf("v%0d_mflo", idx), MDU_Out, v.exp_lo);
    MDUOp = MDU_NONE;
    step();
  endtask

  initial begin
    int n;
    reset = 1'b1; MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;

    //          op         a             b             pre_hi        pre_lo        exp_hi        exp_lo        cyc
    vecs.push_back('{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'h00001234, 32'h00005678, 32'hFFFFFFFF, 32'hFFFFFFF1, 5});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFD, 32'd5,        32'h00001234, 32'h00005678, 32'h00000004, 32'hFFFFFFF1, 5});
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{MDU_DIVU,  32'd7,        32'd2,        32'h00000000, 32'h00000000, 32'h00000001, 32'h00000003, 10});
    vecs.push_back('{MDU_DIV,   32'd100,      32'd0,        32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 10});
    vecs.push_back('{MDU_DIVU,  32'd100,      32'd0,        32'h00000033, 32'h00000044, 32'h00000033, 32'h00000044, 10});
    vecs.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000055, 32'h00000066, 32'h00000000, 32'h80000000, 10});
    vecs.push_back('{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10});
    vecs.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 5});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 5});
    vecs.push_back('{4'd12,     32'h12345678, 32'h9ABCDEF0, 32'h00000077, 32'h00000088, 32'h00000077, 32'h00000088, 0});
`ifdef MDU_MADD_EN
    vecs.push_back('{MDU_MADDU, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5});
    vecs.push_back('{MDU_MADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5});
`else
    vecs.push_back('{MDU_MADDU, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0});
    vecs.push_back('{MDU_MADD,  32'hFFFFFFFF, 32'd1,        32'h00000002, 32'h00000003, 32'h00000002, 32'h00000003, 0});
`endif

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_output("reset_hi", HI, 32'd0);
    check_output("reset_lo", LO, 32'd0);
    check_output("reset_busy", {31'd0, Busy}, 32'd0);
    MDUOp = MDU_MFHI;
    #1;
    check_output("reset_mfhi", MDU_Out, 32'd0);
    MDUOp = MDU_MULT;
    #1;
    check_output("reset_start", {31'd0, Start}, 32'd1);
    MDUOp = MDU_NONE;
    #1;
    check_output("none_start", {31'd0, Start}, 32'd0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(i, vecs[i]);
    end

    // mthi while idle: visible next cycle via mfhi, never busy
    MDUOp = MDU_MTHI; A = 32'hDEADBEEF;
    #1;
    check_output("mthi_start", {31'd0, Start}, 32'd0);
    step();
    check_output("mthi_busy", {31'd0, Busy}, 32'd0);
    MDUOp = MDU_MFHI; A = 32'd0;
    #1;
    check_output("mthi_mfhi", MDU_Out, 32'hDEADBEEF);
    MDUOp = MDU_NONE;
    step();

    // Ops while busy are ignored: mtlo and a second mult
    move_hilo(32'h0000AAAA, 32'h0000BBBB);
    MDUOp = MDU_MULTU; A = 32'd3; B = 32'd4;
    step();
    MDUOp = MDU_MTLO; A = 32'h00000BAD;
    #1;
    check_output("busy_mtlo_start", {31'd0, Start}, 32'd0);
    step();
    MDUOp = MDU_MULT; A = 32'd100; B = 32'd100;
    #1;
    check_output("busy_mult_start", {31'd0, Start}, 32'd0);
    check_output("busy_mtlo_ignored", LO, 32'h0000BBBB);
    step();
    MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;
    n = 2;
    while (Busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
    check_output("busy_total_cycles", 32'(n), 32'd5);
    check_output("busy_result_hi", HI, 32'd0);
    check_output("busy_result_lo", LO, 32'd12);
    step();

    // Reset in the third busy cycle aborts the mult with no later commit
    move_hilo(32'h000000AA, 32'h000000BB);
    MDUOp = MDU_MULT; A = 32'd7; B = 32'd9;
    step();
    MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;
    check_output("abort_busy1", {31'd0, Busy}, 32'd1);
    step();
    step();
    check_output("abort_busy3", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("abort_busy_cleared", {31'd0, Busy}, 32'd0);
    check_output("abort_hi", HI, 32'd0);
    check_output("abort_lo", LO, 32'd0);
    repeat (8) step();
    check_output("abort_no_commit_hi", HI, 32'd0);
    check_output("abort_no_commit_lo", LO, 32'd0);
    check_output("abort_still_idle", {31'd0, Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
    $finish;
  end

endmodule
